// File: rtl/cdru_pkg.sv
// Shared definitions for the banked-memory read arbiter: address geometry defaults,
// priority-mode constants and the bank-field extraction helper.
package cdru_pkg;

    localparam int DEF_BANKBITS = 5;
    localparam int DEF_WORDBITS = 10;
    localparam int A            = DEF_BANKBITS + DEF_WORDBITS;

    localparam int PRIO_FIXED   = 0;
    localparam int PRIO_RR      = 1;

    // Bank select is the field directly above the word-in-bank offset.
    function automatic logic [31:0] bank_field(input logic [31:0] addr,
                                               input int          wordbits,
                                               input int          bankbits);
        logic [31:0] mask;
        mask = (32'd1 << bankbits) - 32'd1;
        return (addr >> wordbits) & mask;
    endfunction

endpackage

// File: rtl/cdru_prio_pick.sv
// Combinational priority walk: starved channels first, then the rest, each group in
// fixed or rotating index order; a channel wins if its bank is still unclaimed.
module cdru_prio_pick
    import cdru_pkg::*;
#(
    parameter int NCHAN     = 3,
    parameter int BANKBITS  = 5,
    parameter int PRIO_MODE = 1,
    parameter int PW        = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic [NCHAN-1:0]          en_i,
    input  logic [NCHAN*BANKBITS-1:0] bank_i,
    input  logic [NCHAN-1:0]          starved_i,
    input  logic [PW-1:0]             rr_ptr_i,
    output logic [NCHAN-1:0]          grant_o,
    output logic                      first_vld_o,
    output logic [PW-1:0]             first_idx_o
);

    // Only granted channels claim a bank, so a denied channel never blocks a later one.
    always_comb begin
        int   idx;
        logic conflict;
        logic take;
        grant_o     = '0;
        first_vld_o = 1'b0;
        first_idx_o = '0;
        idx         = 0;
        conflict    = 1'b0;
        take        = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < NCHAN; k++) begin
                idx      = (PRIO_MODE == PRIO_RR) ? ((int'(rr_ptr_i) + k) % NCHAN) : k;
                conflict = 1'b0;
                for (int j = 0; j < NCHAN; j++) begin
                    conflict = conflict | (grant_o[j] &&
                               (bank_i[j*BANKBITS +: BANKBITS] == bank_i[idx*BANKBITS +: BANKBITS]));
                end
                take         = en_i[idx] && (starved_i[idx] == (pass == 0)) && !conflict;
                grant_o[idx] = grant_o[idx] | take;
                first_idx_o  = (take && !first_vld_o) ? PW'(idx) : first_idx_o;
                first_vld_o  = first_vld_o | take;
            end
        end
    end

endmodule

// File: rtl/cdru_arb.sv
// NCHAN-requester arbiter for a banked memory: one grant per bank per cycle, with
// starvation promotion, optional round-robin rotation and a registered read-issue stage.
module cdru_arb
    import cdru_pkg::*;
#(
    parameter int NCHAN     = 3,
    parameter int BANKBITS  = 5,
    parameter int WORDBITS  = 10,
    parameter int PRIO_MODE = 1,
    parameter int MAXWAIT   = 4,
    parameter int CNTW      = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NCHAN-1:0]                      req_en,
    input  logic [NCHAN*(BANKBITS+WORDBITS)-1:0]  req_addr,
    output logic [NCHAN-1:0]                      req_grnt,
    output logic [NCHAN-1:0]                      rd_vld,
    output logic [NCHAN*(BANKBITS+WORDBITS)-1:0]  rd_addr,
    output logic                                  o_en,
    output logic [NCHAN-1:0]                      stall
);

    localparam int             AW       = BANKBITS + WORDBITS;
    localparam int             PW       = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam logic [CNTW-1:0] WAIT_MAX = CNTW'(MAXWAIT);

    logic [NCHAN*BANKBITS-1:0] bank_s;
    logic [NCHAN-1:0]          starved_s;
    logic [NCHAN-1:0]          grant_s;
    logic [NCHAN-1:0]          denied_s;
    logic                      first_vld_s;
    logic [PW-1:0]             first_idx_s;

    logic [CNTW-1:0]    wait_q [NCHAN];
    logic [CNTW-1:0]    wait_d [NCHAN];
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NCHAN-1:0]   rd_vld_q, stall_q;
    logic [NCHAN*AW-1:0] rd_addr_q, rd_addr_d;
    logic               o_en_q;

    // Bank decode and starvation flags per channel.
    always_comb begin
        bank_s    = '0;
        starved_s = '0;
        for (int i = 0; i < NCHAN; i++) begin
            bank_s[i*BANKBITS +: BANKBITS] =
                BANKBITS'(bank_field(32'(req_addr[i*AW +: AW]), WORDBITS, BANKBITS));
            starved_s[i] = (MAXWAIT > 0) && (wait_q[i] == WAIT_MAX);
        end
    end

    cdru_prio_pick #(
        .NCHAN     (NCHAN),
        .BANKBITS  (BANKBITS),
        .PRIO_MODE (PRIO_MODE),
        .PW        (PW)
    ) u_pick (
        .en_i        (req_en),
        .bank_i      (bank_s),
        .starved_i   (starved_s),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (grant_s),
        .first_vld_o (first_vld_s),
        .first_idx_o (first_idx_s)
    );

    assign denied_s = req_en & ~grant_s;

    // Next state for wait counters, rotation pointer and the captured addresses.
    always_comb begin
        rd_addr_d = rd_addr_q;
        rr_ptr_d  = rr_ptr_q;
        for (int i = 0; i < NCHAN; i++) begin
            if (!req_en[i] || grant_s[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] != WAIT_MAX) begin
                wait_d[i] = wait_q[i] + CNTW'(1);
            end else begin
                wait_d[i] = wait_q[i];
            end
            if (grant_s[i]) begin
                rd_addr_d[i*AW +: AW] = req_addr[i*AW +: AW];
            end else begin
                rd_addr_d[i*AW +: AW] = rd_addr_q[i*AW +: AW];
            end
        end
        // Rotate past the winner only when somebody lost, so idle cycles keep fairness state.
        if ((PRIO_MODE == PRIO_RR) && (|denied_s) && first_vld_s) begin
            rr_ptr_d = (first_idx_s == PW'(NCHAN - 1)) ? '0 : first_idx_s + PW'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // State and read-issue register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCHAN; i++) begin
                wait_q[i] <= '0;
            end
            rr_ptr_q  <= '0;
            rd_vld_q  <= '0;
            rd_addr_q <= '0;
            o_en_q    <= 1'b0;
            stall_q   <= '0;
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                wait_q[i] <= wait_d[i];
            end
            rr_ptr_q  <= rr_ptr_d;
            rd_vld_q  <= grant_s;
            rd_addr_q <= rd_addr_d;
            o_en_q    <= |grant_s;
            stall_q   <= denied_s;
        end
    end

    assign req_grnt = grant_s;
    assign rd_vld   = rd_vld_q;
    assign rd_addr  = rd_addr_q;
    assign o_en     = o_en_q;
    assign stall    = stall_q;

endmodule

// File: doc/cdru_arb.md
Name: cdru_arb

Overview:
- Parametrised, clocked successor to the 3-port conflict-detection read unit.
- Arbitrates NCHAN read requesters competing for BANKS-way banked memory: at most one grant per bank per cycle.
- Supports fixed or rotating priority plus starvation promotion.
- Registers granted requests into a one-cycle read-issue stage that feeds the bank read ports.

Parameters:
- NCHAN, 3, number of requesting channels (2..16).
- BANKBITS, 5, bank-select address bits (upper field of address).
- WORDBITS, 10, word-in-bank address bits (lower field).
- PRIO_MODE, 1, 0 = fixed priority (channel 0 highest, index order); 1 = round-robin rotating priority.
- MAXWAIT, 4, consecutive denials before a channel is promoted to starved; 0 disables promotion.
- CNTW, 3, width of per-channel wait counter; must hold MAXWAIT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_en  in  NCHAN  per-channel read request.
- req_addr  in  NCHAN*(BANKBITS+WORDBITS)  channel i at slice [i*A +: A], A = BANKBITS+WORDBITS; bank = [WORDBITS +: BANKBITS].
- req_grnt  out  NCHAN  combinational same-cycle grant.
- rd_vld  out  NCHAN  registered: channel i granted in previous cycle.
- rd_addr  out  NCHAN*(BANKBITS+WORDBITS)  registered address of each granted channel; holds last value when not valid.
- o_en  out  1  registered OR of rd_vld.
- stall  out  NCHAN  registered: channel was enabled and denied in previous cycle.

Behaviour:
- Reset (async, active-high): rd_vld = 0, rd_addr = 0, o_en = 0, stall = 0, rr_ptr = 0, all wait counters = 0.
- req_grnt is combinational from req_en, req_addr, rr_ptr and counters. It is 0 for any channel with req_en = 0, including during reset.
- Priority order each cycle:
  - Starved channels (wait == MAXWAIT, MAXWAIT > 0) come first, then non-starved channels.
  - Within each group: PRIO_MODE = 0 uses ascending index; PRIO_MODE = 1 uses ascending index starting at rr_ptr, wrapping modulo NCHAN.
- Grant rule: walk channels in priority order. A channel is granted iff req_en = 1 and its bank differs from the bank of every channel already granted this cycle.
- A denied channel never blocks its bank for lower-priority channels.
- Requests to distinct banks are all granted in the same cycle. Equal full addresses still conflict (same bank).
- Latency: grant in cycle N gives rd_vld, rd_addr and o_en in cycle N+1.
- Requester protocol:
  - Hold req_en and req_addr until req_grnt is seen; the transfer completes in the grant cycle.
  - A new request may be presented in the next cycle.
  - Withdrawing (req_en low before grant) is legal; the counter clears.
  - Changing the address while waiting is legal; the counter is kept.
- Wait counter i:
  - Clears on grant or on req_en = 0.
  - Increments, saturating at MAXWAIT, when req_en & ~req_grnt.
- Round-robin pointer (PRIO_MODE = 1 only):
  - When any enabled channel is denied, rr_ptr becomes (highest-priority granted channel + 1) mod NCHAN.
  - Otherwise it holds. In PRIO_MODE = 0 it stays 0.
- stall[i] is the registered value of req_en[i] & ~req_grnt[i].
- Guaranteed progress: with MAXWAIT > 0, any continuously requesting channel is granted within MAXWAIT + NCHAN cycles.
- Reset mid-operation: registered outputs clear immediately; pending requests are re-arbitrated from rr_ptr = 0 after release.

Decomposition:
- Shared package cdru_pkg:
  - localparam A = BANKBITS+WORDBITS
  - prio mode constants PRIO_FIXED = 0, PRIO_RR = 1
  - bank-field extraction function
- Sub-module cdru_prio_pick: combinational priority walk producing the grant vector from enables, banks, starved mask and rr_ptr.
- Top level holds counters, rr_ptr and the output register stage.

Test Plan:
- NCHAN = 3, PRIO_MODE = 0, banks 1/2/3 all enabled -> req_grnt = 3'b111; next cycle rd_vld = 3'b111, o_en = 1, stall = 0.
- PRIO_MODE = 0, ch0 and ch1 both bank 5, ch2 bank 6 -> req_grnt = 3'b101; ch1 granted the cycle after ch0 drops; stall[1] = 1 for one cycle.
- PRIO_MODE = 1, all three channels persistently on bank 7 with immediate re-request, MAXWAIT = 0 -> grant order 0, 1, 2, 0, 1, 2; each channel waits exactly 2 cycles.
- PRIO_MODE = 0, MAXWAIT = 4, ch0 re-requests bank 3 every cycle, ch2 holds bank 3 -> ch2 denied 4 cycles, granted on 5th cycle (req_grnt = 3'b100); ch0 denied that cycle.
- ch1 requests addr 0x1234, granted at cycle N -> rd_addr slice 1 = 0x1234 and rd_vld[1] = 1 at N+1; rd_vld[1] = 0 at N+2 with rd_addr held.
- Assert rst while ch1 is waiting with counter = 3 -> all outputs 0 asynchronously; after release counter restarts at 0, rr_ptr = 0.
